// File: rtl/mips_wb_pkg.sv
// rtl/mips_wb_pkg.sv - shared codes for the MIPS MEM/WB write-back stage
//
// Contents:
//   ld_type_e : load width/sign codes carried from MEM (5-7 decode as LW)
//   wb_sel_e  : write-back source select (WB_RSVD decodes as ALU)
//   REG_ZERO  : hard-wired zero register index, never written

package mips_wb_pkg;

    typedef enum logic [2:0] {
        LD_LW  = 3'd0,
        LD_LB  = 3'd1,
        LD_LBU = 3'd2,
        LD_LH  = 3'd3,
        LD_LHU = 3'd4
    } ld_type_e;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_LINK = 2'd2,
        WB_RSVD = 2'd3
    } wb_sel_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_load_align.sv
// rtl/wb_load_align.sv - little-endian load lane extraction and misalignment check
//
// Ports:
//   i_rdata     [31:0] raw word from data memory
//   i_addr_lo   [1:0]  low bits of the load effective address
//   i_ld_type   [2:0]  load type code (mips_wb_pkg::ld_type_e)
//   o_data      [31:0] aligned, sign/zero extended load value
//   o_misalign         halfword on odd address, or word on non-zero offset
//
// Purely combinational.

module wb_load_align
    import mips_wb_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_ld_type,
    output logic [31:0] o_data,
    output logic        o_misalign
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Byte lane a occupies bits [8a+7:8a]; halfword lane is picked by addr_lo[1].
    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr_lo)
            2'd0: w_byte = i_rdata[7:0];
            2'd1: w_byte = i_rdata[15:8];
            2'd2: w_byte = i_rdata[23:16];
            2'd3: w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
    end

    assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_data     = i_rdata;
        o_misalign = 1'b0;
        case (i_ld_type)
            LD_LB: begin
                o_data = {{24{w_byte[7]}}, w_byte};
            end
            LD_LBU: begin
                o_data = {24'd0, w_byte};
            end
            LD_LH: begin
                o_data     = {{16{w_half[15]}}, w_half};
                o_misalign = i_addr_lo[0];
            end
            LD_LHU: begin
                o_data     = {16'd0, w_half};
                o_misalign = i_addr_lo[0];
            end
            default: begin
                // LW and the unused codes 5-7 all behave as a full-word load.
                o_data     = i_rdata;
                o_misalign = (i_addr_lo != 2'd0);
            end
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MEM/WB pipeline register and register-file write-back formation
//
// Parameters:
//   LINK_OFFSET : added to the instruction PC for link writes (jal/jalr, delay slot)
//
// Ports:
//   clk, reset                  pipeline clock, asynchronous active-high reset
//   stall                       hold WB contents
//   flush                       turn the incoming MEM instruction into a bubble
//   in_valid, in_we, in_rw_no   MEM instruction valid, GPR write, destination
//   in_wb_sel, in_ld_type       result source, load type
//   in_addr_lo                  low bits of the load address
//   in_alu_res, in_mem_rdata    ALU result, raw memory word
//   in_pc                       instruction PC
//   RW_no, Din, WE              register-file write port
//   wb_valid, wb_pc             WB instruction valid and its PC
//   addr_err                    misaligned load in WB
//   retire_cnt [31:0]           retired instruction count (only with WB_RETIRE_CNT_EN)
//
// Optional feature macro: WB_RETIRE_CNT_EN
//
// Outputs are derived only from registered fields, so they settle right after
// posedge and stay stable for the register file's negedge write.

module wb_stage
    import mips_wb_pkg::*;
#(
    parameter logic [31:0] LINK_OFFSET = 32'd8
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        in_valid,
    input  logic        in_we,
    input  logic [4:0]  in_rw_no,
    input  logic [1:0]  in_wb_sel,
    input  logic [2:0]  in_ld_type,
    input  logic [1:0]  in_addr_lo,
    input  logic [31:0] in_alu_res,
    input  logic [31:0] in_mem_rdata,
    input  logic [31:0] in_pc,
    output logic [4:0]  RW_no,
    output logic [31:0] Din,
    output logic        WE,
    output logic        wb_valid,
    output logic [31:0] wb_pc,
    output logic        addr_err
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [31:0] retire_cnt
`endif
);

    logic        r_valid;
    logic        r_we;
    logic [4:0]  r_rw_no;
    logic [1:0]  r_wb_sel;
    logic [2:0]  r_ld_type;
    logic [1:0]  r_addr_lo;
    logic [31:0] r_alu_res;
    logic [31:0] r_mem_rdata;
    logic [31:0] r_pc;
    // Set while an instruction is being held by stall after its first WB
    // cycle; it blocks a second register-file write of the same result.
    logic        r_done;

    logic [31:0] w_ld_data;
    logic        w_misalign;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid     <= 1'b0;
            r_we        <= 1'b0;
            r_rw_no     <= 5'd0;
            r_wb_sel    <= 2'd0;
            r_ld_type   <= 3'd0;
            r_addr_lo   <= 2'd0;
            r_alu_res   <= 32'd0;
            r_mem_rdata <= 32'd0;
            r_pc        <= 32'd0;
            r_done      <= 1'b0;
        end else if (flush) begin
            // Flush wins over stall; the payload fields are left as they were
            // because a bubble's RW_no/Din are don't-care.
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else if (stall) begin
            r_done <= r_valid;
        end else begin
            r_valid     <= in_valid;
            r_we        <= in_we;
            r_rw_no     <= in_rw_no;
            r_wb_sel    <= in_wb_sel;
            r_ld_type   <= in_ld_type;
            r_addr_lo   <= in_addr_lo;
            r_alu_res   <= in_alu_res;
            r_mem_rdata <= in_mem_rdata;
            r_pc        <= in_pc;
            r_done      <= 1'b0;
        end
    end

    wb_load_align u_load_align (
        .i_rdata    (r_mem_rdata),
        .i_addr_lo  (r_addr_lo),
        .i_ld_type  (r_ld_type),
        .o_data     (w_ld_data),
        .o_misalign (w_misalign)
    );

    always_comb begin
        Din = r_alu_res;
        case (r_wb_sel)
            WB_LOAD: Din = w_ld_data;
            WB_LINK: Din = r_pc + LINK_OFFSET;
            default: Din = r_alu_res;
        endcase
    end

    assign RW_no    = r_rw_no;
    assign wb_valid = r_valid;
    assign wb_pc    = r_pc;

    // The misalign flag is only meaningful for a valid load.
    assign addr_err = r_valid && (r_wb_sel == WB_LOAD) && w_misalign;

    assign WE = r_valid && r_we && (r_rw_no != REG_ZERO) && !addr_err && !r_done;

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] r_retire_cnt;

    // Counts every instruction once on leaving its first WB cycle, whether
    // or not it writes a register or faults.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_retire_cnt <= 32'd0;
        end else if (r_valid && !r_done) begin
            r_retire_cnt <= r_retire_cnt + 32'd1;
        end
    end

    assign retire_cnt = r_retire_cnt;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - directed self-checking bench for wb_stage

`timescale 1ns/1ps

module tb_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic        in_we;
    logic [4:0]  in_rw_no;
    logic [1:0]  in_wb_sel;
    logic [2:0]  in_ld_type;
    logic [1:0]  in_addr_lo;
    logic [31:0] in_alu_res;
    logic [31:0] in_mem_rdata;
    logic [31:0] in_pc;
    logic [4:0]  RW_no;
    logic [31:0] Din;
    logic        WE;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic        addr_err;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
`endif

    int tests = 0;
    int fails = 0;

    logic [31:0] rf [32];

    always #5 clk = ~clk;

    wb_stage #(.LINK_OFFSET(32'd8)) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_we        (in_we),
        .in_rw_no     (in_rw_no),
        .in_wb_sel    (in_wb_sel),
        .in_ld_type   (in_ld_type),
        .in_addr_lo   (in_addr_lo),
        .in_alu_res   (in_alu_res),
        .in_mem_rdata (in_mem_rdata),
        .in_pc        (in_pc),
        .RW_no        (RW_no),
        .Din          (Din),
        .WE           (WE),
        .wb_valid     (wb_valid),
        .wb_pc        (wb_pc),
        .addr_err     (addr_err)
`ifdef WB_RETIRE_CNT_EN
        ,
        .retire_cnt   (retire_cnt)
`endif
    );

    // Register-file model: writes at negedge, like the real one.
    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    end
    always @(negedge clk) begin
        if (WE) rf[RW_no] <= Din;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic drive(input logic v, input logic we, input logic [4:0] rw,
                         input logic [1:0] sel, input logic [2:0] ld,
                         input logic [1:0] alo, input logic [31:0] alu,
                         input logic [31:0] rdata, input logic [31:0] pc);
        in_valid     = v;
        in_we        = we;
        in_rw_no     = rw;
        in_wb_sel    = sel;
        in_ld_type   = ld;
        in_addr_lo   = alo;
        in_alu_res   = alu;
        in_mem_rdata = rdata;
        in_pc        = pc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        drive(1'b1, 1'b1, 5'd6, 2'd0, 3'd0, 2'd0, 32'hCAFE_F00D, 32'h1, 32'h100);
        tick();
        tick();
        tests++; if (WE !== 1'b0) begin fails++; $display("FAIL reset_we got %b exp 0", WE); end
        tests++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", wb_valid); end
        tests++; if (Din !== 32'd0) begin fails++; $display("FAIL reset_din got %h exp 0", Din); end
        tests++; if (RW_no !== 5'd0) begin fails++; $display("FAIL reset_rw got %0d exp 0", RW_no); end
        tests++; if (wb_pc !== 32'd0) begin fails++; $display("FAIL reset_pc got %h exp 0", wb_pc); end
        tests++; if (addr_err !== 1'b0) begin fails++; $display("FAIL reset_aerr got %b exp 0", addr_err); end
`ifdef WB_RETIRE_CNT_EN
        tests++; if (retire_cnt !== 32'd0) begin fails++; $display("FAIL reset_cnt got %0d exp 0", retire_cnt); end
`endif
        reset = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 2'd0, 32'd0, 32'd0, 32'd0);
        tick();
    endtask

    task automatic test_alu();
        drive(1'b1, 1'b1, 5'd5, 2'd0, 3'd0, 2'd0, 32'h1234_5678, 32'h0, 32'h0040_0000);
        tick();
        tests++; if (RW_no !== 5'd5) begin fails++; $display("FAIL alu_rw got %0d exp 5", RW_no); end
        tests++; if (Din !== 32'h1234_5678) begin fails++; $display("FAIL alu_din got %h exp 12345678", Din); end
        tests++; if (WE !== 1'b1) begin fails++; $display("FAIL alu_we got %b exp 1", WE); end
        tests++; if (wb_pc !== 32'h0040_0000) begin fails++; $display("FAIL alu_pc got %h exp 00400000", wb_pc); end
        @(negedge clk);
        #1;
        tests++; if (rf[5] !== 32'h1234_5678) begin fails++; $display("FAIL alu_rf5 got %h exp 12345678", rf[5]); end
        drive(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 2'd0, 32'd0, 32'd0, 32'd0);
        tick();
    endtask

    task automatic test_loads();
        logic [2:0]  ld  [5];
        logic [1:0]  a   [5];
        logic [31:0] exp_d [5];
        ld[0] = 3'd1; a[0] = 2'd3; exp_d[0] = 32'hFFFF_FF80;
        ld[1] = 3'd2; a[1] = 2'd1; exp_d[1] = 32'h0000_007F;
        ld[2] = 3'd3; a[2] = 2'd2; exp_d[2] = 32'hFFFF_80FF;
        ld[3] = 3'd4; a[3] = 2'd0; exp_d[3] = 32'h0000_7F01;
        ld[4] = 3'd0; a[4] = 2'd0; exp_d[4] = 32'h80FF_7F01;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 5'd4, 2'd1, ld[i], a[i], 32'hDEAD_BEEF, 32'h80FF_7F01, 32'h200);
            tick();
            tests++; if (Din !== exp_d[i]) begin fails++; $display("FAIL load%0d_din got %h exp %h", i, Din, exp_d[i]); end
            tests++; if (WE !== 1'b1 || addr_err !== 1'b0) begin fails++; $display("FAIL load%0d_we got we=%b aerr=%b exp we=1 aerr=0", i, WE, addr_err); end
        end
        // Unused load code decodes as LW.
        drive(1'b1, 1'b1, 5'd4, 2'd1, 3'd6, 2'd0, 32'h0, 32'h80FF_7F01, 32'h200);
        tick();
        tests++; if (Din !== 32'h80FF_7F01) begin fails++; $display("FAIL load_code6 got %h exp 80ff7f01", Din); end
        drive(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 2'd0, 32'd0, 32'd0, 32'd0);
        tick();
    endtask

    task automatic test_misalign();
        drive(1'b1, 1'b1, 5'd10, 2'd1, 3'd0, 2'd2, 32'h0, 32'h80FF_7F01, 32'h300);
        tick();
        tests++; if (addr_err !== 1'b1 || WE !== 1'b0) begin fails++; $display("FAIL mis_lw got aerr=%b we=%b exp aerr=1 we=0", addr_err, WE); end
        tests++; if (Din !== 32'h80FF_7F01) begin fails++; $display("FAIL mis_lw_din got %h exp 80ff7f01", Din); end
        drive(1'b1, 1'b1, 5'd10, 2'd1, 3'd3, 2'd1, 32'h0, 32'h80FF_7F01, 32'h304);
        tick();
        tests++; if (addr_err !== 1'b1 || WE !== 1'b0) begin fails++; $display("FAIL mis_lh got aerr=%b we=%b exp aerr=1 we=0", addr_err, WE); end
        tests++; if (Din !== 32'h0000_7F01) begin fails++; $display("FAIL mis_lh_din got %h exp 00007f01", Din); end
        // A misaligned-looking address on an ALU op must not flag.
        drive(1'b1, 1'b1, 5'd10, 2'd0, 3'd0, 2'd2, 32'h55, 32'h0, 32'h308);
        tick();
        tests++; if (addr_err !== 1'b0 || WE !== 1'b1) begin fails++; $display("FAIL mis_alu got aerr=%b we=%b exp aerr=0 we=1", addr_err, WE); end
        drive(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 2'd0, 32'd0, 32'd0, 32'd0);
        tick();
    endtask

    task automatic test_link_zero();
        drive(1'b1, 1'b1, 5'd31, 2'd2, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0040_0010);
        tick();
        tests++; if (Din !== 32'h0040_0018) begin fails++; $display("FAIL link_din got %h exp 00400018", Din); end
        tests++; if (WE !== 1'b1 || RW_no !== 5'd31) begin fails++; $display("FAIL link_we got we=%b rw=%0d exp we=1 rw=31", WE, RW_no); end
        drive(1'b1, 1'b1, 5'd0, 2'd0, 3'd0, 2'd0, 32'h9999, 32'h0, 32'h400);
        tick();
        tests++; if (WE !== 1'b0) begin fails++; $display("FAIL zero_we got %b exp 0", WE); end
        drive(1'b1, 1'b0, 5'd12, 2'd0, 3'd0, 2'd0, 32'h9999, 32'h0, 32'h404);
        tick();
        tests++; if (WE !== 1'b0 || wb_valid !== 1'b1) begin fails++; $display("FAIL nowe got we=%b v=%b exp we=0 v=1", WE, wb_valid); end
        drive(1'b0, 1'b1, 5'd12, 2'd0, 3'd0, 2'd0, 32'h9999, 32'h0, 32'h408);
        tick();
        tests++; if (WE !== 1'b0 || wb_valid !== 1'b0) begin fails++; $display("FAIL bubble got we=%b v=%b exp 0 0", WE, wb_valid); end
        tick();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b1, 5'd1, 2'd0, 3'd0, 2'd0, 32'h0000_0011, 32'h0, 32'h500);
        tick();
        tests++; if (Din !== 32'h11 || RW_no !== 5'd1 || WE !== 1'b1) begin fails++; $display("FAIL b2b0 got din=%h rw=%0d we=%b exp 11 1 1", Din, RW_no, WE); end
        drive(1'b1, 1'b1, 5'd2, 2'd1, 3'd2, 2'd2, 32'h0, 32'h80FF_7F01, 32'h504);
        tick();
        tests++; if (Din !== 32'hFF || RW_no !== 5'd2 || WE !== 1'b1) begin fails++; $display("FAIL b2b1 got din=%h rw=%0d we=%b exp ff 2 1", Din, RW_no, WE); end
        drive(1'b1, 1'b1, 5'd3, 2'd2, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0000_0100);
        tick();
        tests++; if (Din !== 32'h108 || RW_no !== 5'd3 || WE !== 1'b1) begin fails++; $display("FAIL b2b2 got din=%h rw=%0d we=%b exp 108 3 1", Din, RW_no, WE); end
        drive(1'b1, 1'b1, 5'd8, 2'd3, 3'd0, 2'd0, 32'h0000_0033, 32'h0, 32'h50C);
        tick();
        tests++; if (Din !== 32'h33) begin fails++; $display("FAIL b2b_rsvd got %h exp 33", Din); end
        drive(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 2'd0, 32'd0, 32'd0, 32'd0);
        @(negedge clk);
        #1;
        tests++; if (rf[1] !== 32'h11 || rf[2] !== 32'hFF || rf[3] !== 32'h108 || rf[8] !== 32'h33) begin
            fails++; $display("FAIL b2b_rf got r1=%h r2=%h r3=%h r8=%h exp 11 ff 108 33", rf[1], rf[2], rf[3], rf[8]);
        end
        tick();
    endtask

    task automatic test_stall_flush();
        reset = 1'b1;
        drive(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 2'd0, 32'd0, 32'd0, 32'd0);
        tick();
        reset = 1'b0;
        drive(1'b1, 1'b1, 5'd7, 2'd0, 3'd0, 2'd0, 32'hA5A5_0007, 32'h0, 32'h600);
        tick();
        tests++; if (WE !== 1'b1) begin fails++; $display("FAIL stall_first_we got %b exp 1", WE); end
        stall = 1'b1;
        drive(1'b1, 1'b1, 5'd3, 2'd0, 3'd0, 2'd0, 32'hDEAD_0000, 32'h0, 32'h700);
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if (WE !== 1'b0) begin fails++; $display("FAIL stall%0d_we got %b exp 0", i, WE); end
            tests++; if (wb_valid !== 1'b1 || RW_no !== 5'd7 || Din !== 32'hA5A5_0007 || wb_pc !== 32'h600) begin
                fails++; $display("FAIL stall%0d_hold got v=%b rw=%0d din=%h pc=%h exp 1 7 a5a50007 600", i, wb_valid, RW_no, Din, wb_pc);
            end
        end
`ifdef WB_RETIRE_CNT_EN
        tests++; if (retire_cnt !== 32'd1) begin fails++; $display("FAIL stall_cnt got %0d exp 1", retire_cnt); end
`endif
        flush = 1'b1;
        tick();
        tests++; if (wb_valid !== 1'b0 || WE !== 1'b0) begin fails++; $display("FAIL flush_stall got v=%b we=%b exp 0 0", wb_valid, WE); end
`ifdef WB_RETIRE_CNT_EN
        tests++; if (retire_cnt !== 32'd1) begin fails++; $display("FAIL flush_cnt got %0d exp 1", retire_cnt); end
`endif
        flush = 1'b0;
        stall = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 2'd0, 32'd0, 32'd0, 32'd0);
        tick();
    endtask

    task automatic test_async_reset();
        drive(1'b1, 1'b1, 5'd9, 2'd0, 3'd0, 2'd0, 32'h0000_0077, 32'h0, 32'h800);
        tick();
        tests++; if (WE !== 1'b1) begin fails++; $display("FAIL areset_pre_we got %b exp 1", WE); end
        #1;
        reset = 1'b1;
        #1;
        tests++; if (WE !== 1'b0 || wb_valid !== 1'b0 || Din !== 32'd0) begin
            fails++; $display("FAIL areset_clear got we=%b v=%b din=%h exp 0 0 0", WE, wb_valid, Din);
        end
`ifdef WB_RETIRE_CNT_EN
        tests++; if (retire_cnt !== 32'd0) begin fails++; $display("FAIL areset_cnt got %0d exp 0", retire_cnt); end
`endif
        @(negedge clk);
        #1;
        tests++; if (rf[9] !== 32'd0) begin fails++; $display("FAIL areset_nowrite got %h exp 0", rf[9]); end
        drive(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 2'd0, 32'd0, 32'd0, 32'd0);
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_loads();
        test_misalign();
        test_link_zero();
        test_back_to_back();
        test_stall_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
